// File: rtl/am_lock_deskew.sv
// am_lock_deskew: per-lane alignment-marker lock plus inter-lane skew monitor.
// Each lane runs an UNLOCK/CAND/LOCKED machine on its AM pulses and captures
// the lane ID carried by the marker. While every lane is locked, the block
// measures slot-to-slot arrival offsets per round and reports alignment.
// Ports:
//   fullclk, rst_n          recovered clock, async active-low reset
//   am_valid/am_corrupt     per-lane AM detect pulse and corrupt qualifier
//   am_field                per-lane 3-bit lane ID from the marker
//   lane_lock, lane_id      per-lane lock flag and captured ID (0 if unlocked)
//   all_locked              every lane locked
//   skew, skew_err          per-lane offsets from the last completed round
//   id_err                  duplicate or out-of-range ID among locked lanes
//   align_done              locked, IDs clean, skew clean, round completed
module am_lock_deskew #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned AM_PERIOD  = 16384,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned MAX_SKEW   = 64,
  parameter int unsigned CNT_W      = $clog2(AM_PERIOD),
  parameter int unsigned SKEW_W     = $clog2(AM_PERIOD/2) + 1
) (
  input  logic                        fullclk,
  input  logic                        rst_n,
  input  logic [NUM_LANES-1:0]        am_valid,
  input  logic [NUM_LANES-1:0]        am_corrupt,
  input  logic [3*NUM_LANES-1:0]      am_field,
  output logic [NUM_LANES-1:0]        lane_lock,
  output logic [3*NUM_LANES-1:0]      lane_id,
  output logic                        all_locked,
  output logic [SKEW_W*NUM_LANES-1:0] skew,
  output logic                        skew_err,
  output logic                        id_err,
  output logic                        align_done
);
  localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);
  localparam int unsigned HALF   = AM_PERIOD / 2;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_CAND   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic [NUM_LANES-1:0] lane_slot;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [2:0]        cand, cand_nxt, id_q, id_nxt;
    logic [MISS_W-1:0] miss, miss_nxt;
    logic [2:0]        fld;
    logic              good, at_slot, cand_hit, lock_hit, lock_q;

    assign good     = am_valid[i] & ~am_corrupt[i];
    assign fld      = am_field[3*i +: 3];
    assign at_slot  = (cnt == CNT_W'(AM_PERIOD - 1));
    assign cand_hit = good & (fld == cand);
    assign lock_hit = good & (fld == id_q);

    // State register
    always_ff @(posedge fullclk or negedge rst_n) begin
      if (!rst_n) state <= ST_UNLOCK;
      else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
      state_nxt = state;
      case (state)
        ST_UNLOCK: if (good) state_nxt = ST_CAND;
        ST_CAND:   if (at_slot) state_nxt = cand_hit ? ST_LOCKED : ST_UNLOCK;
        ST_LOCKED: if (at_slot && !lock_hit && (miss == MISS_W'(LOSS_COUNT - 1)))
                     state_nxt = ST_UNLOCK;
        default:   state_nxt = ST_UNLOCK;
      endcase
    end

    // Counter, candidate, miss and ID updates; slot evaluation beats re-anchor
    always_comb begin
      cnt_nxt  = cnt;
      cand_nxt = cand;
      miss_nxt = miss;
      id_nxt   = id_q;
      case (state)
        ST_UNLOCK: begin
          cnt_nxt = '0;
          if (good) cand_nxt = fld;
        end
        ST_CAND: begin
          if (at_slot) begin
            cnt_nxt = '0;
            if (cand_hit) begin
              id_nxt   = cand;
              miss_nxt = '0;
            end
          end else if (good) begin
            cnt_nxt  = '0;
            cand_nxt = fld;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (at_slot) begin
            cnt_nxt = '0;
            if (lock_hit) begin
              miss_nxt = '0;
            end else if (miss == MISS_W'(LOSS_COUNT - 1)) begin
              miss_nxt = '0;
              id_nxt   = '0;
            end else begin
              miss_nxt = miss + MISS_W'(1);
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt_nxt  = '0;
          miss_nxt = '0;
          id_nxt   = '0;
        end
      endcase
    end

    // Lane datapath registers
    always_ff @(posedge fullclk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        cand   <= '0;
        miss   <= '0;
        id_q   <= '0;
        lock_q <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        cand   <= cand_nxt;
        miss   <= miss_nxt;
        id_q   <= id_nxt;
        lock_q <= (state_nxt == ST_LOCKED);
      end
    end

    assign lane_lock[i]      = lock_q;
    assign lane_id[3*i +: 3] = id_q;
    assign lane_slot[i]      = lock_q & at_slot;
  end

  // Skew round tracking
  logic [CNT_W-1:0]            gap, off, cur_off;
  logic                        open, done, slot_any, start, close, abandon, err_nxt;
  logic [NUM_LANES-1:0]        latched, prev_lat, lat_nxt;
  logic [SKEW_W*NUM_LANES-1:0] shadow, shadow_nxt;

  assign all_locked = &lane_lock;
  assign slot_any   = |lane_slot;
  assign start      = all_locked & ~open & slot_any & (gap == CNT_W'(HALF));

  // Merge this cycle's latches so a round can close in the same cycle
  always_comb begin
    cur_off    = open ? off : '0;
    prev_lat   = open ? latched : '0;
    lat_nxt    = prev_lat | lane_slot;
    shadow_nxt = shadow;
    err_nxt    = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_slot[i] && !prev_lat[i]) shadow_nxt[SKEW_W*i +: SKEW_W] = SKEW_W'(cur_off);
      if (shadow_nxt[SKEW_W*i +: SKEW_W] > SKEW_W'(MAX_SKEW)) err_nxt = 1'b1;
    end
    close   = all_locked & (open | start) & (&lat_nxt);
    abandon = all_locked & open & ~close & (off == CNT_W'(HALF - 1));
  end

  always_ff @(posedge fullclk or negedge rst_n) begin
    if (!rst_n) begin
      gap      <= '0;
      off      <= '0;
      open     <= 1'b0;
      done     <= 1'b0;
      latched  <= '0;
      shadow   <= '0;
      skew     <= '0;
      skew_err <= 1'b0;
    end else if (!all_locked) begin
      gap     <= '0;
      off     <= '0;
      open    <= 1'b0;
      done    <= 1'b0;
      latched <= '0;
    end else begin
      if (slot_any)                   gap <= CNT_W'(1);
      else if (gap != CNT_W'(HALF))   gap <= gap + CNT_W'(1);
      shadow  <= shadow_nxt;
      latched <= lat_nxt;
      if (close) begin
        open     <= 1'b0;
        done     <= 1'b1;
        skew     <= shadow_nxt;
        skew_err <= err_nxt;
      end else if (abandon) begin
        open <= 1'b0;
      end else if (start) begin
        open <= 1'b1;
        off  <= CNT_W'(1);
      end else if (open) begin
        off <= off + CNT_W'(1);
      end
    end
  end

  // ID consistency across locked lanes; 4-bit compare keeps NUM_LANES=8 legal
  always_comb begin
    id_err = 1'b0;
    for (int a = 0; a < NUM_LANES; a++) begin
      if (lane_lock[a] && ({1'b0, lane_id[3*a +: 3]} >= 4'(NUM_LANES))) id_err = 1'b1;
      for (int b = a + 1; b < NUM_LANES; b++) begin
        if (lane_lock[a] && lane_lock[b] && (lane_id[3*a +: 3] == lane_id[3*b +: 3]))
          id_err = 1'b1;
      end
    end
  end

  assign align_done = all_locked & ~id_err & ~skew_err & done;

endmodule

// File: tb/tb_am_lock_deskew.sv
// Randomized bench for am_lock_deskew with a timestamp-based reference model.
module tb_am_lock_deskew;
  localparam int N = 4, P = 256, HALF = 128, LOSS = 4, MAXS = 64, SW = 8;

  logic fullclk = 1'b0;
  logic rst_n;
  logic [N-1:0]    am_valid, am_corrupt;
  logic [3*N-1:0]  am_field;
  logic [N-1:0]    lane_lock;
  logic [3*N-1:0]  lane_id;
  logic            all_locked, skew_err, id_err, align_done;
  logic [SW*N-1:0] skew;

  am_lock_deskew #(.NUM_LANES(N), .AM_PERIOD(P), .LOSS_COUNT(LOSS), .MAX_SKEW(MAXS)) dut (
    .fullclk(fullclk), .rst_n(rst_n), .am_valid(am_valid), .am_corrupt(am_corrupt),
    .am_field(am_field), .lane_lock(lane_lock), .lane_id(lane_id), .all_locked(all_locked),
    .skew(skew), .skew_err(skew_err), .id_err(id_err), .align_done(align_done));

  always #5 fullclk = ~fullclk;

  int checks = 0, errors = 0;
  int t = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, t, act, exp);
    end
  endtask

  // Reference model: lane state 0=unlocked 1=candidate 2=locked, times are absolute cycles
  int m_st[N], m_anc[N], m_cid[N], m_lid[N], m_miss[N], offs[N], m_skew[N];
  bit al_prev, ropen, m_err, m_done;
  int gref, ro;

  logic [N-1:0] en_lock, ec_lock;
  logic [3*N-1:0] en_id, ec_id;
  logic [SW*N-1:0] en_skew, ec_skew;
  logic en_all, ec_all, en_err, ec_err, en_iderr, ec_iderr, en_align, ec_align;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_anc[i] = 0; m_cid[i] = 0; m_lid[i] = 0; m_miss[i] = 0;
      offs[i] = -1; m_skew[i] = 0;
    end
    al_prev = 0; ropen = 0; m_err = 0; m_done = 0; gref = 0; ro = 0;
    en_lock = '0; en_id = '0; en_all = 0; en_skew = '0; en_err = 0; en_iderr = 0; en_align = 0;
    ec_lock = '0; ec_id = '0; ec_all = 0; ec_skew = '0; ec_err = 0; ec_iderr = 0; ec_align = 0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] c, input logic [3*N-1:0] f);
    bit al, any, alln, good;
    bit [N-1:0] slot;
    int gap, fid;
    al = 1; any = 0;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] != 2) al = 0;
      slot[i] = (m_st[i] == 2) && (((t - m_anc[i]) % P) == 0);
      if (slot[i]) any = 1;
    end
    if (!al) begin
      al_prev = 0; ropen = 0; m_done = 0;
    end else begin
      if (!al_prev) begin al_prev = 1; gref = t; end
      gap = (t - gref >= HALF) ? HALF : (t - gref);
      if (!ropen && any && gap == HALF) begin
        ropen = 1; ro = t;
        for (int i = 0; i < N; i++) offs[i] = -1;
      end
      if (ropen) begin
        alln = 1;
        for (int i = 0; i < N; i++) begin
          if (slot[i] && offs[i] < 0) offs[i] = t - ro;
          if (offs[i] < 0) alln = 0;
        end
        if (alln) begin
          ropen = 0; m_done = 1; m_err = 0;
          for (int i = 0; i < N; i++) begin
            m_skew[i] = offs[i];
            if (offs[i] > MAXS) m_err = 1;
          end
        end else if (t - ro == HALF - 1) ropen = 0;
      end
      if (any) gref = t;
    end
    for (int i = 0; i < N; i++) begin
      good = v[i] && !c[i];
      fid = int'(f[3*i +: 3]);
      case (m_st[i])
        0: if (good) begin m_st[i] = 1; m_anc[i] = t; m_cid[i] = fid; end
        1: begin
          if (t - m_anc[i] == P) begin
            if (good && fid == m_cid[i]) begin m_st[i] = 2; m_lid[i] = m_cid[i]; m_miss[i] = 0; end
            else m_st[i] = 0;
          end else if (good) begin
            m_anc[i] = t; m_cid[i] = fid;
          end
        end
        default: begin
          if (((t - m_anc[i]) % P) == 0) begin
            if (good && fid == m_lid[i]) m_miss[i] = 0;
            else begin
              m_miss[i]++;
              if (m_miss[i] == LOSS) begin m_st[i] = 0; m_lid[i] = 0; end
            end
          end
        end
      endcase
    end
    en_iderr = 0;
    for (int a = 0; a < N; a++) begin
      en_lock[a] = (m_st[a] == 2);
      en_id[3*a +: 3] = en_lock[a] ? 3'(m_lid[a]) : 3'd0;
      en_skew[SW*a +: SW] = SW'(m_skew[a]);
    end
    for (int a = 0; a < N; a++) begin
      if (en_lock[a] && m_lid[a] >= N) en_iderr = 1;
      for (int b = a + 1; b < N; b++)
        if (en_lock[a] && en_lock[b] && m_lid[a] == m_lid[b]) en_iderr = 1;
    end
    en_all = &en_lock;
    en_err = m_err;
    en_align = en_all && !en_iderr && !m_err && m_done;
  endtask

  // Per-cycle comparison against the model
  bit chk_en = 0;
  always @(negedge fullclk) begin
    if (chk_en) begin
      chk("lane_lock", 64'(lane_lock), 64'(ec_lock));
      chk("lane_id", 64'(lane_id), 64'(ec_id));
      chk("all_locked", 64'(all_locked), 64'(ec_all));
      chk("skew", 64'(skew), 64'(ec_skew));
      chk("skew_err", 64'(skew_err), 64'(ec_err));
      chk("id_err", 64'(id_err), 64'(ec_iderr));
      chk("align_done", 64'(align_done), 64'(ec_align));
    end
  end

  // Stimulus knobs
  int ph[N], idc[N], force_cor[N];
  int p_cor = 0, p_spur = 0, p_badid = 0;
  int first_am_t = -1, lock_seen_t = -1;

  // One clock cycle; entered and left 2 time units after a rising edge
  task automatic cycle();
    logic [N-1:0] v, c;
    logic [3*N-1:0] f;
    for (int i = 0; i < N; i++) begin
      if ((t % P) == ph[i]) begin
        v[i] = 1'b1;
        if (force_cor[i] > 0) begin c[i] = 1'b1; force_cor[i]--; end
        else c[i] = (int'($urandom_range(99)) < p_cor);
        f[3*i +: 3] = (int'($urandom_range(99)) < p_badid) ? 3'($urandom_range(7)) : 3'(idc[i]);
      end else begin
        v[i] = (int'($urandom_range(999)) < p_spur);
        c[i] = 1'($urandom_range(1));
        f[3*i +: 3] = 3'($urandom_range(7));
      end
    end
    am_valid = v; am_corrupt = c; am_field = f;
    if (first_am_t < 0 && v[0] && !c[0]) first_am_t = t;
    if (rst_n) model_step(v, c, f);
    @(posedge fullclk);
    ec_lock = en_lock; ec_id = en_id; ec_all = en_all; ec_skew = en_skew;
    ec_err = en_err; ec_iderr = en_iderr; ec_align = en_align;
    #1;
    if (all_locked && lock_seen_t < 0) lock_seen_t = t;
    t++;
    #1;
  endtask

  task automatic run(input int nper);
    repeat (nper * P) cycle();
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_lock"}, 64'(lane_lock), 64'd0);
    chk({tag, "_id"}, 64'(lane_id), 64'd0);
    chk({tag, "_all"}, 64'(all_locked), 64'd0);
    chk({tag, "_skew"}, 64'(skew), 64'd0);
    chk({tag, "_serr"}, 64'(skew_err), 64'd0);
    chk({tag, "_iderr"}, 64'(id_err), 64'd0);
    chk({tag, "_align"}, 64'(align_done), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    zero_checks(tag);
    repeat (3) cycle();
    rst_n = 1'b1;
    first_am_t = -1;
    lock_seen_t = -1;
  endtask

  task automatic cfg(input int p0, input int p1, input int p2, input int p3,
                     input int i0, input int i1, input int i2, input int i3);
    ph[0] = p0; ph[1] = p1; ph[2] = p2; ph[3] = p3;
    idc[0] = i0; idc[1] = i1; idc[2] = i2; idc[3] = i3;
  endtask

  initial begin
    int guard, base;
    rst_n = 1'b0; am_valid = '0; am_corrupt = '0; am_field = '0;
    for (int i = 0; i < N; i++) force_cor[i] = 0;
    cfg(0, 0, 0, 0, 0, 1, 2, 3);
    model_reset();
    chk_en = 1;
    repeat (3) @(posedge fullclk);
    #2;
    zero_checks("reset");
    rst_n = 1'b1;

    // Clean aligned lanes
    run(4);
    chk("lock_latency", 64'(lock_seen_t - first_am_t), 64'(P));
    chk("s1_align", 64'(align_done), 64'd1);
    chk("s1_skew", 64'(skew), 64'd0);
    chk("s1_serr", 64'(skew_err), 64'd0);

    // Lane 2 late by 40
    cfg(0, 0, 40, 0, 0, 1, 2, 3);
    do_reset("rst2");
    run(4);
    chk("s2_skew", 64'(skew), 64'h0028_0000);
    chk("s2_serr", 64'(skew_err), 64'd0);
    chk("s2_align", 64'(align_done), 64'd1);

    // Lane 2 late by 70, then reset inside an open round
    cfg(0, 0, 70, 0, 0, 1, 2, 3);
    do_reset("rst3");
    run(4);
    chk("s3_skew", 64'(skew), 64'h0046_0000);
    chk("s3_serr", 64'(skew_err), 64'd1);
    chk("s3_align", 64'(align_done), 64'd0);
    guard = 0;
    while ((t % P) != 30 && guard < P) begin cycle(); guard++; end
    do_reset("midround");
    run(4);
    chk("relock_all", 64'(all_locked), 64'd1);

    // Lane 3 early by 10 across the wrap
    cfg(0, 0, 0, P - 10, 0, 1, 2, 3);
    do_reset("rst4");
    run(4);
    chk("s4_skew", 64'(skew), 64'h000A_0A0A);
    chk("s4_align", 64'(align_done), 64'd1);

    // Corrupt markers on lane 1
    cfg(0, 0, 0, 0, 0, 1, 2, 3);
    do_reset("rst5");
    run(4);
    force_cor[1] = 3;
    run(4);
    chk("s5_keep_lock", 64'(lane_lock), 64'hF);
    force_cor[1] = 4;
    guard = 0;
    while (force_cor[1] > 0 && guard < 5 * P) begin cycle(); guard++; end
    chk("s5_lost_lock1", 64'(lane_lock[1]), 64'd0);
    chk("s5_lost_align", 64'(align_done), 64'd0);
    run(1);

    // Duplicate IDs on lanes 0 and 2
    cfg(0, 0, 0, 0, 1, 0, 1, 3);
    do_reset("rst6");
    run(3);
    chk("s6_all", 64'(all_locked), 64'd1);
    chk("s6_iderr", 64'(id_err), 64'd1);
    chk("s6_align", 64'(align_done), 64'd0);

    // Randomized phases, IDs and marker faults
    p_cor = 3; p_spur = 2; p_badid = 2;
    for (int r = 0; r < 6; r++) begin
      base = int'($urandom_range(P - 1));
      for (int i = 0; i < N; i++) begin
        ph[i] = (base + int'($urandom_range(90))) % P;
        idc[i] = (int'($urandom_range(99)) < 20) ? int'($urandom_range(7)) : i;
      end
      do_reset("rstr");
      run(6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
